controller_sequencer: RTL and testbench

SAP-1 controller-sequencer. A six-state ring counter walks each instruction through fetch (T1–T3) and execute (T4–T6). It decodes the 4-bit opcode from the instruction register into the 12-bit control word that drives the PC, MAR, RAM, IR, accumulator, adder-subtractor (Su/Eu), B register and output register. It is the only block that asserts the adder-subtractor's subtract select and output enable.

---
 rtl/controller_sequencer_if.sv | 11 +
 rtl/controller_sequencer.sv | 107 ++++++++++
 tb/tb_controller_sequencer.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/controller_sequencer_if.sv
// Instruction-side bundle of the SAP-1 controller-sequencer.
// The sequencer is the slave: it takes the opcode in and drives CON, T and HLT_N out.
interface controller_sequencer_if;
  logic [3:0]  opcode;
  logic [11:0] con;
  logic [5:0]  t;
  logic        hlt_n;

  modport master (output opcode, input con, t, hlt_n);
  modport slave  (input opcode, output con, t, hlt_n);
endinterface

// File: rtl/controller_sequencer.sv
// SAP-1 controller-sequencer: a six-state one-hot ring (T1..T6) plus a sticky halt flag.
// The 12-bit control word is decoded combinationally from the ring state and the opcode.
module controller_sequencer (
  input  logic                   clk_i,
  input  logic                   clr_n_i,
  controller_sequencer_if.slave  bus
);

  // Control word bit order: {Cp, Ep, Lm_N, CE_N, Li_N, Ei_N, La_N, Ea, Su, Eu, Lb_N, Lo_N}
  localparam logic [11:0] CON_NOP     = 12'h3E3;
  localparam logic [11:0] CON_FETCH1  = 12'h5E3;
  localparam logic [11:0] CON_FETCH2  = 12'hBE3;
  localparam logic [11:0] CON_FETCH3  = 12'h263;
  localparam logic [11:0] CON_MEM_ADR = 12'h1A3;
  localparam logic [11:0] CON_LDA_T5  = 12'h2C3;
  localparam logic [11:0] CON_LD_B    = 12'h2E1;
  localparam logic [11:0] CON_ADD_T6  = 12'h3C7;
  localparam logic [11:0] CON_SUB_T6  = 12'h3CF;
  localparam logic [11:0] CON_OUT_T4  = 12'h3F2;

  localparam logic [3:0] OP_LDA = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_OUT = 4'b1110;
  localparam logic [3:0] OP_HLT = 4'b1111;

  typedef enum logic [5:0] {
    T1 = 6'b000001,
    T2 = 6'b000010,
    T3 = 6'b000100,
    T4 = 6'b001000,
    T5 = 6'b010000,
    T6 = 6'b100000
  } state_e;

  state_e      state_q, state_d;
  logic        halt_q, halt_d;
  logic [11:0] con_w;

  always_ff @(posedge clk_i or negedge clr_n_i) begin
    if (!clr_n_i) begin
      state_q <= T1;
      halt_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      halt_q  <= halt_d;
    end
  end

  // Once halted the ring parks on T5 until reset.
  always_comb begin
    state_d = state_q;
    halt_d  = halt_q;
    if (!halt_q) begin
      case (state_q)
        T1: state_d = T2;
        T2: state_d = T3;
        T3: state_d = T4;
        T4: begin
          state_d = T5;
          if (bus.opcode == OP_HLT) halt_d = 1'b1;
        end
        T5: state_d = T6;
        T6: state_d = T1;
        default: state_d = T1;
      endcase
    end
  end

  always_comb begin
    con_w = CON_NOP;
    case (state_q)
      T1: con_w = CON_FETCH1;
      T2: con_w = CON_FETCH2;
      T3: con_w = CON_FETCH3;
      T4: begin
        case (bus.opcode)
          OP_LDA, OP_ADD, OP_SUB: con_w = CON_MEM_ADR;
          OP_OUT:                 con_w = CON_OUT_T4;
          default:                con_w = CON_NOP;
        endcase
      end
      T5: begin
        case (bus.opcode)
          OP_LDA:         con_w = CON_LDA_T5;
          OP_ADD, OP_SUB: con_w = CON_LD_B;
          default:        con_w = CON_NOP;
        endcase
      end
      T6: begin
        case (bus.opcode)
          OP_ADD:  con_w = CON_ADD_T6;
          OP_SUB:  con_w = CON_SUB_T6;
          default: con_w = CON_NOP;
        endcase
      end
      default: con_w = CON_NOP;
    endcase
    // Reset overrides the T1 decode so no Ep/Lm_N pulse leaks out while CLR_N is low.
    if (!clr_n_i || halt_q) con_w = CON_NOP;
  end

  assign bus.con   = con_w;
  assign bus.t     = state_q;
  assign bus.hlt_n = ~halt_q;

endmodule

// File: tb/tb_controller_sequencer.sv
// Randomized bench for controller_sequencer against a step-index/lookup-table reference model.
module tb_controller_sequencer;

  logic clk = 1'b0;
  logic clr_n;

  controller_sequencer_if bus ();

  controller_sequencer dut (
    .clk_i   (clk),
    .clr_n_i (clr_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int vec_cnt = 0;
  int err_cnt = 0;

  // Reference model: which of the six instruction steps we are in (0 = T1), and halt status.
  int step_m    = 0;
  bit halted_m  = 1'b0;

  task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h want %h (t=%0t step=%0d op=%h)", tag, obs, exp, $time, step_m, bus.opcode);
    end
  endtask

  function automatic logic [11:0] model_con(int step, logic [3:0] op, bit in_rst, bit halted);
    if (in_rst || halted) return 12'h3E3;
    case (step)
      0: return 12'h5E3;
      1: return 12'hBE3;
      2: return 12'h263;
      3: begin
        if (op == 4'h0 || op == 4'h1 || op == 4'h2) return 12'h1A3;
        if (op == 4'hE) return 12'h3F2;
        return 12'h3E3;
      end
      4: begin
        if (op == 4'h0) return 12'h2C3;
        if (op == 4'h1 || op == 4'h2) return 12'h2E1;
        return 12'h3E3;
      end
      5: begin
        if (op == 4'h1) return 12'h3C7;
        if (op == 4'h2) return 12'h3CF;
        return 12'h3E3;
      end
      default: return 12'h3E3;
    endcase
  endfunction

  task automatic check_all();
    logic [11:0] exp;
    logic [5:0]  t_exp;
    exp   = model_con(step_m, bus.opcode, !clr_n, halted_m);
    t_exp = 6'b000001 << step_m;
    chk("con",   bus.con, exp);
    chk("su",    {11'b0, bus.con[3]}, {11'b0, exp[3]});
    chk("t",     {6'b0, bus.t}, {6'b0, t_exp});
    chk("hlt_n", {11'b0, bus.hlt_n}, {11'b0, ~halted_m});
  endtask

  // Opcode only changes at the start of an instruction so it is stable through T4..T6.
  task automatic run_cycle(input logic [3:0] op);
    if (step_m == 0 && !halted_m) bus.opcode = op;
    @(posedge clk);
    if (clr_n) begin
      if (halted_m) begin
        step_m = 4;
      end else if (step_m == 3 && bus.opcode == 4'hF) begin
        halted_m = 1'b1;
        step_m   = 4;
      end else begin
        step_m = (step_m + 1) % 6;
      end
    end
    @(negedge clk);
    check_all();
  endtask

  task automatic run_instr(input logic [3:0] op);
    repeat (6) run_cycle(op);
  endtask

  // Reset is asserted between edges and must take effect without waiting for a clock.
  task automatic reset_pulse(input int hold);
    #2;
    clr_n    = 1'b0;
    step_m   = 0;
    halted_m = 1'b0;
    #1;
    check_all();
    repeat (hold) run_cycle(bus.opcode);
    clr_n = 1'b1;
    #1;
    check_all();
  endtask

  initial begin
    logic [3:0] op;
    logic [3:0] dir_ops [6];
    dir_ops = '{4'h0, 4'h1, 4'h2, 4'h1, 4'hE, 4'h5};

    bus.opcode = 4'b0001;
    clr_n      = 1'b1;
    #1;
    clr_n      = 1'b0;
    #1;
    check_all();
    repeat (3) run_cycle(4'b0001);
    clr_n = 1'b1;
    #1;
    check_all();

    foreach (dir_ops[i]) run_instr(dir_ops[i]);

    run_instr(4'hF);
    repeat (20) run_cycle(4'h0);
    reset_pulse(2);

    repeat (4) run_cycle(4'h1);
    reset_pulse(2);
    run_instr(4'h0);

    for (int n = 0; n < 60; n++) begin
      op = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 7) == 0) begin
        repeat ($urandom_range(1, 5)) run_cycle(op);
        reset_pulse($urandom_range(1, 3));
      end else begin
        run_instr(op);
        if (halted_m) begin
          repeat ($urandom_range(3, 10)) run_cycle(op);
          reset_pulse(1);
        end
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
